// File: rtl/arith_issue_ctrl.sv
// Command front-end for the 16-bit arithmetic unit: registers operands, waits a
// per-operation settle time, captures results and keeps a multi-word carry/borrow chain.
module arith_issue_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MUL_WAIT = 1,
    parameter int DIV_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_a,
    input  logic [WIDTH-1:0] i_cmd_b,
    input  logic             i_cmd_chain,
    input  logic             i_clear_chain,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [WIDTH-1:0] o_rsp_aux,
    output logic [3:0]       o_rsp_flags,
    output logic             o_chain_carry,
    output logic             o_chain_borrow,
    output logic [WIDTH-1:0] o_au_in0,
    output logic [WIDTH-1:0] o_au_in1,
    output logic [1:0]       o_au_sel,
    output logic             o_au_carryin,
    output logic             o_au_borrowin,
    input  logic [WIDTH-1:0] i_au_result,
    input  logic [WIDTH-1:0] i_au_upper,
    input  logic [WIDTH-1:0] i_au_rem,
    input  logic             i_au_carryout,
    input  logic             i_au_borrowout,
    input  logic             i_au_ovf,
    input  logic             i_au_dbz
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [2:0] MUL_CNT = 3'(MUL_WAIT);
    localparam logic [2:0] DIV_CNT = 3'(DIV_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic [WIDTH-1:0] r_rsp_aux;
    logic [3:0]       r_rsp_flags;
    logic             r_chain_carry;
    logic             r_chain_borrow;
    logic [WIDTH-1:0] r_au_in0;
    logic [WIDTH-1:0] r_au_in1;
    logic [1:0]       r_au_sel;
    logic             r_au_carryin;
    logic             r_au_borrowin;

    logic             w_accept;
    logic             w_capture;
    logic [2:0]       w_wait_load;
    logic [WIDTH-1:0] w_aux;

    assign w_accept  = i_cmd_valid && (r_state == IDLE);
    assign w_capture = (r_state == SETTLE) && (r_cnt == 3'd0);

    always_comb begin
        w_wait_load = 3'd0;
        w_aux       = '0;
        case (i_cmd_op)
            OP_MUL:  w_wait_load = MUL_CNT;
            OP_DIV:  w_wait_load = DIV_CNT;
            default: w_wait_load = 3'd0;
        endcase
        case (r_au_sel)
            OP_MUL:  w_aux = i_au_upper;
            OP_DIV:  w_aux = i_au_rem;
            default: w_aux = '0;
        endcase
    end

    // Operand/select registers stay at their last value after capture so the unit's outputs remain stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= 3'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_aux     <= '0;
            r_rsp_flags   <= 4'b0000;
            r_au_in0      <= '0;
            r_au_in1      <= '0;
            r_au_sel      <= OP_ADD;
            r_au_carryin  <= 1'b0;
            r_au_borrowin <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_au_in0      <= i_cmd_a;
                        r_au_in1      <= i_cmd_b;
                        r_au_sel      <= i_cmd_op;
                        r_au_carryin  <= i_cmd_chain && (i_cmd_op == OP_ADD) && r_chain_carry;
                        r_au_borrowin <= i_cmd_chain && (i_cmd_op == OP_SUB) && r_chain_borrow;
                        r_cnt         <= w_wait_load;
                        r_state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_rsp_result <= i_au_result;
                        r_rsp_aux    <= w_aux;
                        r_rsp_flags  <= {i_au_dbz, i_au_ovf, i_au_borrowout, i_au_carryout};
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // The capture update takes priority over an external clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain_carry  <= 1'b0;
            r_chain_borrow <= 1'b0;
        end else if (w_capture) begin
            r_chain_carry  <= (r_au_sel == OP_ADD) && i_au_carryout;
            r_chain_borrow <= (r_au_sel == OP_SUB) && i_au_borrowout;
        end else if (i_clear_chain) begin
            r_chain_carry  <= 1'b0;
            r_chain_borrow <= 1'b0;
        end
    end

    assign o_cmd_ready    = (r_state == IDLE);
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_result   = r_rsp_result;
    assign o_rsp_aux      = r_rsp_aux;
    assign o_rsp_flags    = r_rsp_flags;
    assign o_chain_carry  = r_chain_carry;
    assign o_chain_borrow = r_chain_borrow;
    assign o_au_in0       = r_au_in0;
    assign o_au_in1       = r_au_in1;
    assign o_au_sel       = r_au_sel;
    assign o_au_carryin   = r_au_carryin;
    assign o_au_borrowin  = r_au_borrowin;

endmodule

// File: tb/tb_arith_issue_ctrl.sv
// Directed bench for arith_issue_ctrl with a behavioural arithmetic unit attached.
module tb_arith_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [15:0] cmdA;
    logic [15:0] cmdB;
    logic        cmdChain;
    logic        clearChain;
    logic        rspValid;
    logic        rspReady;
    logic [15:0] rspResult;
    logic [15:0] rspAux;
    logic [3:0]  rspFlags;
    logic        chainCarry;
    logic        chainBorrow;
    logic [15:0] auIn0;
    logic [15:0] auIn1;
    logic [1:0]  auSel;
    logic        auCarryIn;
    logic        auBorrowIn;
    logic [15:0] auResult;
    logic [15:0] auUpper;
    logic [15:0] auRem;
    logic        auCarryOut;
    logic        auBorrowOut;
    logic        auOvf;
    logic        auDbz;

    int checkCount = 0;
    int passCount  = 0;

    arith_issue_ctrl #(.WIDTH(16), .MUL_WAIT(1), .DIV_WAIT(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cmd_valid   (cmdValid),
        .o_cmd_ready   (cmdReady),
        .i_cmd_op      (cmdOp),
        .i_cmd_a       (cmdA),
        .i_cmd_b       (cmdB),
        .i_cmd_chain   (cmdChain),
        .i_clear_chain (clearChain),
        .o_rsp_valid   (rspValid),
        .i_rsp_ready   (rspReady),
        .o_rsp_result  (rspResult),
        .o_rsp_aux     (rspAux),
        .o_rsp_flags   (rspFlags),
        .o_chain_carry (chainCarry),
        .o_chain_borrow(chainBorrow),
        .o_au_in0      (auIn0),
        .o_au_in1      (auIn1),
        .o_au_sel      (auSel),
        .o_au_carryin  (auCarryIn),
        .o_au_borrowin (auBorrowIn),
        .i_au_result   (auResult),
        .i_au_upper    (auUpper),
        .i_au_rem      (auRem),
        .i_au_carryout (auCarryOut),
        .i_au_borrowout(auBorrowOut),
        .i_au_ovf      (auOvf),
        .i_au_dbz      (auDbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in arithmetic unit; divide by zero returns all-ones quotient and the dividend as remainder.
    always_comb begin
        logic [16:0] wide;
        logic [31:0] prod;
        wide        = 17'd0;
        prod        = 32'd0;
        auResult    = 16'd0;
        auUpper     = 16'd0;
        auRem       = 16'd0;
        auCarryOut  = 1'b0;
        auBorrowOut = 1'b0;
        auOvf       = 1'b0;
        auDbz       = 1'b0;
        case (auSel)
            2'b00: begin
                wide       = {1'b0, auIn0} + {1'b0, auIn1} + {16'd0, auCarryIn};
                auResult   = wide[15:0];
                auCarryOut = wide[16];
                auOvf      = (auIn0[15] == auIn1[15]) && (wide[15] != auIn0[15]);
            end
            2'b01: begin
                wide        = {1'b0, auIn0} - {1'b0, auIn1} - {16'd0, auBorrowIn};
                auResult    = wide[15:0];
                auBorrowOut = wide[16];
                auOvf       = (auIn0[15] != auIn1[15]) && (wide[15] != auIn0[15]);
            end
            2'b10: begin
                prod     = auIn0 * auIn1;
                auResult = prod[15:0];
                auUpper  = prod[31:16];
            end
            default: begin
                if (auIn1 == 16'd0) begin
                    auResult = 16'hFFFF;
                    auRem    = auIn0;
                    auDbz    = 1'b1;
                end else begin
                    auResult = auIn0 / auIn1;
                    auRem    = auIn0 % auIn1;
                end
            end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic chain);
        cmdOp    = op;
        cmdA     = a;
        cmdB     = b;
        cmdChain = chain;
        cmdValid = 1'b1;
        checkOutput("cmdReadyBeforeAccept", {31'd0, cmdReady}, 32'd1);
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        cmdChain = 1'b0;
    endtask

    task automatic waitResponse(output int latency);
        latency = 0;
        while (!rspValid && latency < 20) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic takeResponse();
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic chain, input int expLat, input logic expCin, input logic expBin,
                         input logic [15:0] expRes, input logic [15:0] expAux, input logic [3:0] expFlags,
                         input logic expCarry, input logic expBorrow);
        int lat;
        applyStimulus(op, a, b, chain);
        checkOutput({tag, ".carryin"}, {31'd0, auCarryIn}, {31'd0, expCin});
        checkOutput({tag, ".borrowin"}, {31'd0, auBorrowIn}, {31'd0, expBin});
        waitResponse(lat);
        checkOutput({tag, ".latency"}, lat, expLat);
        checkOutput({tag, ".result"}, {16'd0, rspResult}, {16'd0, expRes});
        checkOutput({tag, ".aux"}, {16'd0, rspAux}, {16'd0, expAux});
        checkOutput({tag, ".flags"}, {28'd0, rspFlags}, {28'd0, expFlags});
        checkOutput({tag, ".chainCarry"}, {31'd0, chainCarry}, {31'd0, expCarry});
        checkOutput({tag, ".chainBorrow"}, {31'd0, chainBorrow}, {31'd0, expBorrow});
        takeResponse();
        checkOutput({tag, ".idleAfterRsp"}, {30'd0, cmdReady, rspValid}, 32'b10);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int lat;
        int sawValid;
        rst_n      = 1'b0;
        cmdValid   = 1'b0;
        cmdOp      = 2'b00;
        cmdA       = 16'd0;
        cmdB       = 16'd0;
        cmdChain   = 1'b0;
        clearChain = 1'b0;
        rspReady   = 1'b0;

        #12;
        checkOutput("reset.cmdReady", {31'd0, cmdReady}, 32'd1);
        checkOutput("reset.rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("reset.rspResult", {16'd0, rspResult}, 32'd0);
        checkOutput("reset.rspAux", {16'd0, rspAux}, 32'd0);
        checkOutput("reset.rspFlags", {28'd0, rspFlags}, 32'd0);
        checkOutput("reset.chain", {30'd0, chainCarry, chainBorrow}, 32'd0);
        checkOutput("reset.auOperands", {auIn0, auIn1}, 32'd0);
        checkOutput("reset.auCtrl", {28'd0, auSel, auCarryIn, auBorrowIn}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //            tag        op     a        b        ch  lat cin bin result   aux      flags    cc  cb
        runOp("addOvf",   2'b00, 16'h7FFF, 16'h0001, 0, 1, 0, 0, 16'h8000, 16'h0000, 4'b0100, 0, 0);
        runOp("addCarry", 2'b00, 16'hFFFF, 16'h0001, 0, 1, 0, 0, 16'h0000, 16'h0000, 4'b0001, 1, 0);
        runOp("addChain", 2'b00, 16'h0000, 16'h0000, 1, 1, 1, 0, 16'h0001, 16'h0000, 4'b0000, 0, 0);
        runOp("subBorrow",2'b01, 16'h0000, 16'h0001, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 4'b0010, 0, 1);
        runOp("addNoCin", 2'b00, 16'h0004, 16'h0001, 1, 1, 0, 0, 16'h0005, 16'h0000, 4'b0000, 0, 0);
        runOp("subBorrow2",2'b01,16'h0000, 16'h0001, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 4'b0010, 0, 1);
        runOp("subChain", 2'b01, 16'h0005, 16'h0002, 1, 1, 0, 1, 16'h0002, 16'h0000, 4'b0000, 0, 0);
        runOp("mul",      2'b10, 16'h0100, 16'h0100, 0, 2, 0, 0, 16'h0000, 16'h0001, 4'b0000, 0, 0);
        runOp("addCarry2",2'b00, 16'hFFFF, 16'h0001, 0, 1, 0, 0, 16'h0000, 16'h0000, 4'b0001, 1, 0);
        runOp("divZero",  2'b11, 16'h0007, 16'h0000, 0, 3, 0, 0, 16'hFFFF, 16'h0007, 4'b1000, 0, 0);
        runOp("div",      2'b11, 16'h0011, 16'h0005, 0, 3, 0, 0, 16'h0003, 16'h0002, 4'b0000, 0, 0);

        // Explicit chain clear while idle.
        runOp("addCarry3",2'b00, 16'hFFFF, 16'h0001, 0, 1, 0, 0, 16'h0000, 16'h0000, 4'b0001, 1, 0);
        clearChain = 1'b1;
        @(posedge clk);
        #1;
        clearChain = 1'b0;
        checkOutput("clearChain.carry", {31'd0, chainCarry}, 32'd0);

        // Response back-pressure with a second command waiting.
        cmdOp    = 2'b00;
        cmdA     = 16'h0001;
        cmdB     = 16'h0002;
        cmdValid = 1'b1;
        @(posedge clk);
        #1;
        cmdA = 16'h00AA;
        cmdB = 16'h0055;
        waitResponse(lat);
        checkOutput("hold.latency", lat, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold.rspValid", {31'd0, rspValid}, 32'd1);
            checkOutput("hold.rspResult", {16'd0, rspResult}, 32'h0003);
            checkOutput("hold.rspFlags", {28'd0, rspFlags}, 32'd0);
            checkOutput("hold.cmdReady", {31'd0, cmdReady}, 32'd0);
            checkOutput("hold.auIn0", {16'd0, auIn0}, 32'h0001);
        end
        takeResponse();
        checkOutput("hold.notYetAccepted", {16'd0, auIn0}, 32'h0001);
        checkOutput("hold.readyAgain", {31'd0, cmdReady}, 32'd1);
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        checkOutput("hold.secondAccepted", {auIn0, auIn1}, 32'h00AA_0055);
        waitResponse(lat);
        checkOutput("hold.secondResult", {16'd0, rspResult}, 32'h00FF);
        takeResponse();

        // Reset in the middle of a divide settle.
        runOp("addCarry4",2'b00, 16'hFFFF, 16'h0001, 0, 1, 0, 0, 16'h0000, 16'h0000, 4'b0001, 1, 0);
        applyStimulus(2'b11, 16'h0009, 16'h0003, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("midReset.chain", {30'd0, chainCarry, chainBorrow}, 32'd0);
        checkOutput("midReset.cmdReady", {31'd0, cmdReady}, 32'd1);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        sawValid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rspValid) sawValid = 1;
        end
        checkOutput("midReset.noResponse", sawValid, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
